// File: rtl/sound_scheduler.sv
// Round-robin scheduler sharing the three-mode sound datapath between three
// requesters. Latches one-cycle tone requests, grants one at a time on the
// one-hot cv select, waits for the datapath done (or a timeout/abort), then
// holds cv silent for a fixed gap before the next grant.
module sound_scheduler #(
    parameter int unsigned CNT_W          = 26,
    parameter int unsigned TIMEOUT_CYCLES = 50000000,
    parameter int unsigned GAP_CYCLES     = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       abort,
    input  logic       dp_done,
    output logic [2:0] cv,
    output logic       busy,
    output logic [2:0] pending,
    output logic [2:0] served,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_GAP
    } state_t;

    // Last count value of a PLAY window and of a GAP window.
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [2:0]       cv_q, cv_d;
    logic [2:0]       pending_q, pending_d;
    logic [2:0]       served_q, served_d;
    logic             terr_q, terr_d;

    logic             grant_vld;
    logic [1:0]       grant_idx;
    logic [2:0]       grant_clr;

    // Arbiter: first pending channel searching ptr, ptr-1, ptr-2 (mod 3).
    always_comb begin
        logic [1:0] cidx;
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        cidx      = ptr_q;
        for (int unsigned k = 0; k < 3; k++) begin
            cidx = 2'((32'(ptr_q) + 32'd3 - k) % 32'd3);
            if (!grant_vld && pending_q[cidx]) begin
                grant_vld = 1'b1;
                grant_idx = cidx;
            end
        end
    end

    // Next-state logic for the IDLE -> PLAY -> GAP -> IDLE sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        cv_d      = cv_q;
        served_d  = '0;
        terr_d    = terr_q;
        grant_clr = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    cv_d      = 3'b001 << grant_idx;
                    grant_clr = 3'b001 << grant_idx;
                    ptr_d     = 2'((32'(grant_idx) + 32'd2) % 32'd3);
                    cnt_d     = '0;
                    state_d   = S_PLAY;
                end
            end
            S_PLAY: begin
                cnt_d = cnt_q + 1'b1;
                // A qualified done outranks both abort and timeout; done is
                // ignored on the first PLAY cycle while the datapath settles.
                if (dp_done && (cnt_q != '0)) begin
                    served_d = cv_q;
                    cv_d     = '0;
                    cnt_d    = '0;
                    state_d  = S_GAP;
                end else if (abort) begin
                    cv_d    = '0;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (cnt_q == TO_LAST) begin
                    terr_d  = 1'b1;
                    cv_d    = '0;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                cv_d = '0;
                if ((GAP_CYCLES == 0) || (cnt_q == GAP_LAST)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cv_d    = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Abort beats a same-cycle request; a request beats a same-cycle grant clear.
        if (abort) begin
            pending_d = '0;
        end else begin
            pending_d = (pending_q & ~grant_clr) | req;
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ptr_q     <= 2'd2;
            cv_q      <= '0;
            pending_q <= '0;
            served_q  <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            cv_q      <= cv_d;
            pending_q <= pending_d;
            served_q  <= served_d;
            terr_q    <= terr_d;
        end
    end

    assign cv          = cv_q;
    assign busy        = (state_q != S_IDLE);
    assign pending     = pending_q;
    assign served      = served_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Scoreboard bench for sound_scheduler: stimulus pushes expected grants and
// served pulses into queues, a negedge monitor pops and compares them.
module tb_sound_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic       abort;
    logic       dp_done;
    logic [2:0] cv;
    logic       busy;
    logic [2:0] pending;
    logic [2:0] served;
    logic       timeout_err;

    logic [2:0] grant_q[$];
    logic [2:0] served_q[$];
    logic [2:0] prev_cv = 3'b000;

    int errors = 0;
    int checks = 0;

    sound_scheduler #(
        .CNT_W(8),
        .TIMEOUT_CYCLES(20),
        .GAP_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .abort(abort),
        .dp_done(dp_done),
        .cv(cv),
        .busy(busy),
        .pending(pending),
        .served(served),
        .timeout_err(timeout_err)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [2:0] v);
        req = v;
        step();
        req = 3'b000;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_grant();
        int n = 0;
        while (cv == 3'b000 && n < 100) begin
            step();
            n++;
        end
        check("grant_seen", {31'b0, cv != 3'b000}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check("idle_seen", {31'b0, busy}, 32'd0);
    endtask

    task automatic serve(input int delay);
        logic [2:0] exp;
        wait_grant();
        repeat (delay) step();
        exp = cv;
        dp_done = 1'b1;
        served_q.push_back(exp);
        step();
        dp_done = 1'b0;
        check("serve_cv_drop", cv, 0);
        check("served_pulse", served, exp);
        step();
        check("served_one_cycle", served, 0);
        wait_idle();
    endtask

    // Monitor: compare every new grant and every served pulse against the queues.
    always @(negedge clk) begin
        if (prev_cv == 3'b000 && cv != 3'b000) begin
            if (grant_q.size() == 0) check("grant_unexpected", cv, 0);
            else check("grant_order", cv, grant_q.pop_front());
        end
        if (served != 3'b000) begin
            if (served_q.size() == 0) check("served_unexpected", served, 0);
            else check("served_value", served, served_q.pop_front());
        end
        prev_cv = cv;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        req = 3'b000;
        abort = 1'b0;
        dp_done = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_cv", cv, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_served", served, 0);
        check("rst_terr", timeout_err, 0);

        // 1. Single tone with full gap
        grant_q.push_back(3'b100);
        pulse_req(3'b100);
        check("t1_pending", pending, 3'b100);
        check("t1_cv_not_yet", cv, 0);
        step();
        check("t1_cv", cv, 3'b100);
        check("t1_busy", busy, 1);
        check("t1_pending_clr", pending, 0);
        repeat (10) step();
        dp_done = 1'b1;
        served_q.push_back(3'b100);
        step();
        dp_done = 1'b0;
        check("t1_cv_drop", cv, 0);
        check("t1_served", served, 3'b100);
        check("t1_gap_busy0", busy, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1_gap_cv", cv, 0);
            check("t1_gap_busy", busy, 1);
            check("t1_gap_served", served, 0);
        end
        step();
        check("t1_idle", busy, 0);

        // 2. Simultaneous requests after reset
        reset_dut();
        grant_q.push_back(3'b100);
        grant_q.push_back(3'b010);
        grant_q.push_back(3'b001);
        pulse_req(3'b111);
        check("t2_pending0", pending, 3'b111);
        step();
        check("t2_cv0", cv, 3'b100);
        check("t2_pending1", pending, 3'b011);
        dp_done = 1'b1;
        step();
        dp_done = 1'b0;
        check("t2_done_cnt0_ignored", cv, 3'b100);
        check("t2_done_cnt0_served", served, 0);
        serve(3);
        wait_grant();
        check("t2_pending2", pending, 3'b001);
        serve(2);
        wait_grant();
        check("t2_pending3", pending, 3'b000);
        serve(5);

        // 3. Round-robin rotation
        reset_dut();
        grant_q.push_back(3'b010);
        pulse_req(3'b010);
        serve(4);
        grant_q.push_back(3'b001);
        grant_q.push_back(3'b100);
        grant_q.push_back(3'b010);
        pulse_req(3'b111);
        serve(1);
        serve(1);
        serve(1);

        // 4. Timeout after 20 PLAY cycles
        check("t4_terr_pre", timeout_err, 0);
        grant_q.push_back(3'b100);
        pulse_req(3'b100);
        wait_grant();
        n = 0;
        while (cv != 3'b000 && n < 100) begin
            step();
            n++;
        end
        check("t4_play_len", n, 20);
        check("t4_terr", timeout_err, 1);
        check("t4_served", served, 0);
        wait_idle();
        check("t4_terr_sticky", timeout_err, 1);

        // 6. Reset mid-PLAY with pending requests
        grant_q.push_back(3'b100);
        pulse_req(3'b100);
        wait_grant();
        pulse_req(3'b011);
        check("t6_pending", pending, 3'b011);
        check("t6_cv", cv, 3'b100);
        reset_dut();
        check("t6_cv_rst", cv, 0);
        check("t6_busy_rst", busy, 0);
        check("t6_pending_rst", pending, 0);
        check("t6_terr_rst", timeout_err, 0);
        grant_q.push_back(3'b100);
        grant_q.push_back(3'b010);
        grant_q.push_back(3'b001);
        pulse_req(3'b111);
        serve(1);
        serve(1);
        serve(1);

        // 5a. Abort mid-PLAY with pending=011
        grant_q.push_back(3'b100);
        pulse_req(3'b100);
        wait_grant();
        pulse_req(3'b011);
        check("t5_pending", pending, 3'b011);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5_abort_cv", cv, 0);
        check("t5_abort_pending", pending, 0);
        check("t5_abort_served", served, 0);
        wait_idle();
        repeat (8) step();
        check("t5_no_regrant_cv", cv, 0);
        check("t5_no_regrant_busy", busy, 0);

        // 5b. dp_done and abort in the same cycle
        grant_q.push_back(3'b010);
        pulse_req(3'b010);
        wait_grant();
        pulse_req(3'b001);
        check("t5b_pending", pending, 3'b001);
        step();
        dp_done = 1'b1;
        abort = 1'b1;
        served_q.push_back(3'b010);
        step();
        dp_done = 1'b0;
        abort = 1'b0;
        check("t5b_served", served, 3'b010);
        check("t5b_cv", cv, 0);
        check("t5b_pending", pending, 0);
        wait_idle();
        repeat (8) step();
        check("t5b_idle_cv", cv, 0);

        // All expected events observed
        check("grant_q_drained", grant_q.size(), 0);
        check("served_q_drained", served_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
